// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage.
package fetch_pkg;
    typedef enum logic {FETCH, FLUSH} fetch_state_e;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fq_entry_t;
    localparam int INSTR_BYTES = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO with push/pop/clear and occupancy count, async reset.
module fetch_queue #(
    parameter int W = 32,
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [AW:0]   count
);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] rd, wr;
    logic full, do_push, do_pop;
    assign full = count == (AW+1)'(DEPTH);
    assign do_pop = pop && count != '0;
    assign do_push = push && (!full || do_pop);
    assign dout = mem[rd];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem <= '{default: '0};
            rd <= '0;
            wr <= '0;
            count <= '0;
        end else if (clear) begin
            rd <= '0;
            wr <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wr] <= din;
                wr <= wr + 1'b1;
            end
            if (do_pop) rd <= rd + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    overflow: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop && !clear));
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC, credit-limited in-order imem requests, fetch queue, redirect flush.
// Optional FETCH_PERF_CNT_EN adds saturating delivered/bubble counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int XLEN = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int FQ_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr_out,
    output logic [XLEN-1:0] pc_out
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     perf_delivered,
    output logic [31:0]     perf_bubble
`endif
);
    localparam int CW = $clog2(FQ_DEPTH) + 1;
    fetch_state_e state, state_next;
    logic [XLEN-1:0] pc, tag_pc;
    logic [2*XLEN-1:0] head;
    logic [CW-1:0] outstanding, stale, out_next, stale_next, occ, tag_count;
    logic [CW:0] used;
    logic req_fire, rsp_live, pop;
    assign req_fire = imem_req_valid && imem_req_ready;
    assign rsp_live = imem_rsp_valid && stale == '0;
    assign pop = instr_valid && instr_ready;
    assign out_next = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
    // A redirect turns everything still in flight after this cycle into stale responses.
    assign stale_next = redirect_valid ? out_next : stale - CW'(imem_rsp_valid && stale != '0);
    assign used = {1'b0, outstanding} + {1'b0, occ};
    assign imem_addr = pc;
    assign instr_valid = occ != '0;
    assign instr_out = head[XLEN-1:0];
    assign pc_out = head[2*XLEN-1:XLEN];
    fetch_queue #(.W(XLEN), .DEPTH(FQ_DEPTH)) u_tag (
        .clk(clk), .rst(rst), .clear(redirect_valid), .push(req_fire), .pop(rsp_live),
        .din(pc), .dout(tag_pc), .count(tag_count)
    );
    fetch_queue #(.W(2*XLEN), .DEPTH(FQ_DEPTH)) u_fq (
        .clk(clk), .rst(rst), .clear(redirect_valid), .push(rsp_live), .pop(pop),
        .din({tag_pc, imem_rsp_data}), .dout(head), .count(occ)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FETCH;
        else state <= state_next;
    end
    always_comb begin
        state_next = redirect_valid ? (out_next != '0 ? FLUSH : FETCH)
                   : (state == FLUSH && stale_next == '0) ? FETCH : state;
    end
    always_comb begin
        imem_req_valid = !rst && state == FETCH && used < (CW+1)'(FQ_DEPTH);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
            outstanding <= '0;
            stale <= '0;
        end else begin
            pc <= redirect_valid ? redirect_pc & ~XLEN'(INSTR_BYTES - 1)
                : req_fire ? pc + XLEN'(INSTR_BYTES) : pc;
            outstanding <= out_next;
            stale <= stale_next;
        end
    end
    tag_sync: assert property (@(posedge clk) disable iff (rst) stale != '0 || tag_count == outstanding);
`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_delivered <= '0;
            perf_bubble <= '0;
        end else begin
            if (pop && perf_delivered != '1) perf_delivered <= perf_delivered + 1'b1;
            if (!instr_valid && perf_bubble != '1) perf_bubble <= perf_bubble + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized bench; model = sequential program stream restarted at each redirect.
module tb_fetch_unit;
    import fetch_pkg::*;
    localparam int DEPTH = 2;
    logic clk = 1'b0, rst = 1'b1;
    logic imem_req_valid, imem_req_ready = 1'b0, imem_rsp_valid = 1'b0;
    logic redirect_valid = 1'b0, instr_valid, instr_ready = 1'b0;
    logic [31:0] imem_addr, imem_rsp_data = '0, redirect_pc = '0, instr_out, pc_out;
    always #5 clk = ~clk;
    fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .FQ_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_out(instr_out), .pc_out(pc_out)
    );
    int n_cmp = 0, n_bad = 0, cyc = 0, stale = 0, delivered = 0;
    int lat_lo = 1, lat_hi = 1;
    bit rnd_ready = 0, rnd_dec = 0, stall = 0, redir_prev = 0;
    bit s_req_valid, s_instr_valid, s_pop, s_acc, s_rsp;
    logic [31:0] s_pop_pc, s_acc_addr, exp_fetch = '0, exp_pc = '0;
    fq_entry_t pend[$];
    int due[$];
    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ NOP;
    endfunction
    // One clock cycle: drive memory/decode/redirect at negedge, check, then advance the model.
    task automatic step(input bit redir, input logic [31:0] tgt);
        bit rsp;
        @(negedge clk);
        rsp = pend.size() > 0 && due[0] <= cyc;
        imem_rsp_valid = rsp;
        imem_rsp_data = rsp ? pend[0].instr : $urandom;
        imem_req_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        instr_ready = stall ? 1'b0 : rnd_dec ? 1'($urandom_range(0, 1)) : 1'b1;
        redirect_valid = redir;
        redirect_pc = tgt;
        #1;
        s_req_valid = imem_req_valid;
        s_instr_valid = instr_valid;
        s_acc = imem_req_valid && imem_req_ready;
        s_pop = instr_valid && instr_ready;
        s_rsp = rsp;
        if (stale > 0) begin
            n_cmp++;
            if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL req_in_flush: req_valid=%b required 0 (cyc %0d)", imem_req_valid, cyc); end
        end
        if (stale > 0 || redir_prev) begin
            n_cmp++;
            if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL valid_after_redirect: instr_valid=%b required 0 (cyc %0d)", instr_valid, cyc); end
        end
        if (s_acc) begin
            n_cmp++;
            if (imem_addr !== exp_fetch) begin n_bad++; $display("FAIL fetch_addr: got %h required %h (cyc %0d)", imem_addr, exp_fetch, cyc); end
            s_acc_addr = imem_addr;
            pend.push_back('{pc: imem_addr, instr: mem_data(imem_addr)});
            due.push_back(cyc + $urandom_range(lat_lo, lat_hi));
            exp_fetch += 32'd4;
        end
        if (s_pop) begin
            n_cmp += 2;
            if (pc_out !== exp_pc) begin n_bad++; $display("FAIL pc_out: got %h required %h (cyc %0d)", pc_out, exp_pc, cyc); end
            if (instr_out !== mem_data(exp_pc)) begin n_bad++; $display("FAIL instr_out: got %h required %h (cyc %0d)", instr_out, mem_data(exp_pc), cyc); end
            s_pop_pc = pc_out;
            exp_pc += 32'd4;
            delivered++;
        end
        if (rsp) begin
            void'(pend.pop_front());
            void'(due.pop_front());
            if (stale > 0) stale--;
        end
        n_cmp++;
        if (pend.size() > DEPTH) begin n_bad++; $display("FAIL credit: outstanding %0d exceeds %0d (cyc %0d)", pend.size(), DEPTH, cyc); end
        if (redir) begin
            stale = pend.size();
            exp_fetch = tgt & ~32'd3;
            exp_pc = tgt & ~32'd3;
        end
        redir_prev = redir;
        @(posedge clk);
        cyc++;
    endtask
    task automatic test_reset();
        #2;
        n_cmp += 4;
        if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL rst_req_valid: got %b required 0", imem_req_valid); end
        if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL rst_instr_valid: got %b required 0", instr_valid); end
        if (instr_out !== 32'h0) begin n_bad++; $display("FAIL rst_instr_out: got %h required 0", instr_out); end
        if (pc_out !== 32'h0) begin n_bad++; $display("FAIL rst_pc_out: got %h required 0", pc_out); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask
    task automatic test_stream();
        int d0;
        bit first;
        first = 1;
        d0 = delivered;
        for (int i = 0; i < 30; i++) begin
            step(0, 0);
            if (s_pop && first) begin
                first = 0;
                n_cmp++;
                if (s_pop_pc !== 32'h0) begin n_bad++; $display("FAIL first_pc: got %h required 0", s_pop_pc); end
            end
        end
        n_cmp++;
        if (delivered - d0 < 15) begin n_bad++; $display("FAIL stream_rate: got %0d pops required >=15", delivered - d0); end
    endtask
    task automatic test_stall();
        int acc;
        acc = 0;
        stall = 1;
        for (int i = 0; i < 10; i++) begin step(0, 0); acc += int'(s_acc); end
        n_cmp += 3;
        if (acc > DEPTH) begin n_bad++; $display("FAIL stall_reqs: got %0d required <=%0d", acc, DEPTH); end
        if (s_req_valid !== 1'b0) begin n_bad++; $display("FAIL stall_req_valid: got %b required 0", s_req_valid); end
        if (s_instr_valid !== 1'b1) begin n_bad++; $display("FAIL stall_instr_valid: got %b required 1", s_instr_valid); end
        stall = 0;
        for (int i = 0; i < 12; i++) step(0, 0);
    endtask
    task automatic test_redirect_flush();
        bit got;
        lat_lo = 3;
        lat_hi = 3;
        for (int i = 0; i < 30 && pend.size() < 2; i++) step(0, 0);
        n_cmp++;
        if (pend.size() != 2) begin n_bad++; $display("FAIL inflight: got %0d required 2", pend.size()); end
        step(1, 32'h100);
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin step(0, 0); got = s_pop; end
        n_cmp++;
        if (!got || s_pop_pc !== 32'h100) begin n_bad++; $display("FAIL flush_first_pc: got %h (seen %b) required 00000100", s_pop_pc, got); end
        for (int i = 0; i < 8; i++) step(0, 0);
    endtask
    task automatic test_redirect_pop_rsp();
        bit hit, got;
        hit = 0;
        lat_lo = 1;
        lat_hi = 1;
        for (int i = 0; i < 30 && !hit; i++) begin
            #1;
            if (instr_valid && pend.size() > 0 && due[0] <= cyc) begin
                step(1, 32'h400);
                hit = 1;
                n_cmp++;
                if (!(s_pop && s_rsp)) begin n_bad++; $display("FAIL coincide: pop=%b rsp=%b required 1 1", s_pop, s_rsp); end
            end else step(0, 0);
        end
        n_cmp++;
        if (!hit) begin n_bad++; $display("FAIL coincide_setup: got 0 required 1"); end
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin step(0, 0); got = s_pop; end
        n_cmp++;
        if (!got || s_pop_pc !== 32'h400) begin n_bad++; $display("FAIL coincide_next_pc: got %h required 00000400", s_pop_pc); end
    endtask
    task automatic test_align_wrap();
        bit got;
        int n;
        logic [31:0] a1;
        a1 = '0;
        step(1, 32'h103);
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin step(0, 0); got = s_acc; end
        n_cmp++;
        if (!got || s_acc_addr !== 32'h100) begin n_bad++; $display("FAIL align: got %h required 00000100", s_acc_addr); end
        step(1, 32'hFFFF_FFFC);
        n = 0;
        for (int i = 0; i < 30 && n < 2; i++) begin
            step(0, 0);
            if (s_acc) begin n++; if (n == 1) a1 = s_acc_addr; end
        end
        n_cmp += 2;
        if (n < 2 || a1 !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_a: got %h required fffffffc", a1); end
        if (n < 2 || s_acc_addr !== 32'h0) begin n_bad++; $display("FAIL wrap_b: got %h required 00000000", s_acc_addr); end
        for (int i = 0; i < 10; i++) step(0, 0);
    endtask
    task automatic test_reset_flush();
        bit got;
        lat_lo = 3;
        lat_hi = 3;
        for (int i = 0; i < 30 && pend.size() < 2; i++) step(0, 0);
        step(1, 32'h200);
        #2;
        rst = 1'b1;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        imem_req_ready = 1'b0;
        #1;
        n_cmp += 4;
        if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_req: got %b required 0", imem_req_valid); end
        if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_valid: got %b required 0", instr_valid); end
        if (instr_out !== 32'h0) begin n_bad++; $display("FAIL mid_rst_instr: got %h required 0", instr_out); end
        if (pc_out !== 32'h0) begin n_bad++; $display("FAIL mid_rst_pc: got %h required 0", pc_out); end
        pend.delete();
        due.delete();
        stale = 0;
        redir_prev = 0;
        exp_fetch = '0;
        exp_pc = '0;
        lat_lo = 1;
        lat_hi = 1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin step(0, 0); got = s_pop; end
        n_cmp++;
        if (!got || s_pop_pc !== 32'h0) begin n_bad++; $display("FAIL restart_pc: got %h required 00000000", s_pop_pc); end
    endtask
    task automatic test_random();
        lat_lo = 1;
        lat_hi = 4;
        rnd_ready = 1;
        rnd_dec = 1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) step(1, $urandom);
            else step(0, 0);
        end
        rnd_ready = 0;
        rnd_dec = 0;
        for (int i = 0; i < 12; i++) step(0, 0);
        n_cmp++;
        if (delivered < 100) begin n_bad++; $display("FAIL total_delivered: got %0d required >=100", delivered); end
    endtask
    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_flush();
        test_redirect_pop_rsp();
        test_align_wrap();
        test_reset_flush();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
